// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory
// between the fetch port and the data port, with data priority.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   i_req/i_addr    fetch request, held until i_valid
//   i_rdata/i_valid registered fetch word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_be  data request, held until d_valid
//   d_rdata/d_valid registered load data and one-cycle completion pulse
//   stall_f/stall_m combinational stall lines into the hazard logic
//   m_req/m_we/m_addr/m_wdata/m_be  registered memory request, held until m_ack
//   m_rdata/m_ack   memory read data and one-cycle completion
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_valid,
    output logic            stall_f,
    output logic            stall_m,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arbState_t;

    arbState_t     state;
    arbState_t     stateNext;
    logic [CW-1:0] starveCnt;
    logic          effI;
    logic          effD;
    logic          limitHit;
    logic          grantI;
    logic          grantD;
    logic          ackSeen;

    // A port whose valid pulse is up this cycle is already satisfied,
    // so it neither stalls nor competes for a new grant.
    assign effI     = i_req & ~i_valid;
    assign effD     = d_req & ~d_valid;
    assign stall_f  = effI;
    assign stall_m  = effD;
    assign limitHit = (starveCnt >= LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        ackSeen   = 1'b0;
        unique case (state)
            IDLE: begin
                // Data wins unless fetch has already lost LIMIT times running.
                if (effD && (!effI || !limitHit)) begin
                    grantD    = 1'b1;
                    stateNext = SERVE_D;
                end else if (effI) begin
                    grantI    = 1'b1;
                    stateNext = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (m_ack) begin
                    ackSeen   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (grantD) begin
            if (!effI) begin
                starveCnt <= '0;
            end else if (!limitHit) begin
                starveCnt <= starveCnt + CW'(1);
            end
        end else if (grantI) begin
            starveCnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (grantD) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
            end else if (grantI) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
                m_be    <= '0;
            end else if (ackSeen) begin
                m_req <= 1'b0;
                if (state == SERVE_I) begin
                    i_valid <= 1'b1;
                    i_rdata <= m_rdata;
                end else begin
                    d_valid <= 1'b1;
                    // Stores complete without touching the load result.
                    if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random fetch/data traffic against a scoreboard
// and a transaction-level model of arbitration and memory contents.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          stall_f;
    logic          stall_m;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_valid(i_valid),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_be(d_be),
        .d_rdata(d_rdata),
        .d_valid(d_valid),
        .stall_f(stall_f),
        .stall_m(stall_m),
        .m_req(m_req),
        .m_we(m_we),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_be(m_be),
        .m_rdata(m_rdata),
        .m_ack(m_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    int   errors = 0;
    int   checks = 0;
    txn_t iQ[$];
    txn_t dQ[$];

    // reference data memory (word granular) and the responder's byte store
    logic [31:0] refMem[logic [31:0]];
    logic [7:0]  ramB[logic [31:0]];

    bit monOn   = 1'b0;
    bit respOn  = 1'b0;
    bit lateAck = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] romWord(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ramRead(logic [31:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = ramB.exists(a + b) ? ramB[a + b] : 8'h00;
        end
        return r;
    endfunction

    // memory responder: random 0..3 wait cycles, stray acks while idle
    initial begin
        int lat;
        lat     = -1;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack   = 1'b0;
            m_rdata = $urandom;
            if (!respOn) begin
                m_ack = lateAck;
                lat   = -1;
            end else if (m_req) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                if (lat == 0) begin
                    m_ack = 1'b1;
                    if (m_addr < 32'h20000) begin
                        m_rdata = romWord(m_addr);
                    end else begin
                        m_rdata = ramRead(m_addr);
                    end
                    if (m_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_be[b]) ramB[m_addr + b] = m_wdata[b*8 +: 8];
                        end
                    end
                    lat = -1;
                end else begin
                    lat--;
                end
            end else begin
                lat = -1;
                if ($urandom_range(0, 7) == 0) m_ack = 1'b1;
            end
        end
    end

    // transaction-level model state for the monitor
    bit          busy;
    bit          port;
    int          streak;
    bit          pI, pD, pAck, pIV, pDV;
    bit          nIV, nDV, newGrant, ei, ed;
    logic [31:0] lastD;
    txn_t        t;

    always @(negedge clk) begin
        if (monOn) begin
            nIV      = 1'b0;
            nDV      = 1'b0;
            newGrant = 1'b0;
            if (busy) begin
                if (pAck) begin
                    busy = 1'b0;
                    if (port) nDV = 1'b1;
                    else nIV = 1'b1;
                end
            end else begin
                ei = pI && !pIV;
                ed = pD && !pDV;
                if (ed && (!ei || streak < LIMIT)) begin
                    busy     = 1'b1;
                    port     = 1'b1;
                    streak   = ei ? streak + 1 : 0;
                    newGrant = 1'b1;
                end else if (ei) begin
                    busy     = 1'b1;
                    port     = 1'b0;
                    streak   = 0;
                    newGrant = 1'b1;
                end
            end
            check("m_req", 32'(m_req), 32'(busy));
            if (newGrant && port) begin
                if (dQ.size() == 0) begin
                    check("d grant without request", 32'(1), 32'(0));
                end else begin
                    check("d grant m_addr", m_addr, dQ[0].addr);
                    check("d grant m_we", 32'(m_we), 32'(dQ[0].we));
                    if (dQ[0].we) begin
                        check("d grant m_wdata", m_wdata, dQ[0].wdata);
                        check("d grant m_be", 32'(m_be), 32'(dQ[0].be));
                    end
                end
            end
            if (newGrant && !port) begin
                if (iQ.size() == 0) begin
                    check("i grant without request", 32'(1), 32'(0));
                end else begin
                    check("i grant m_addr", m_addr, iQ[0].addr);
                    check("i grant m_we/m_be", 32'({m_we, m_be}), 32'(0));
                    check("i grant m_wdata", m_wdata, 32'(0));
                end
            end
            check("i_valid", 32'(i_valid), 32'(nIV));
            check("d_valid", 32'(d_valid), 32'(nDV));
            if (nIV && iQ.size() > 0) begin
                t = iQ.pop_front();
                check("i_rdata", i_rdata, t.rdata);
            end
            if (nDV && dQ.size() > 0) begin
                t = dQ.pop_front();
                if (t.we) begin
                    check("d_rdata kept on store", d_rdata, lastD);
                end else begin
                    check("d_rdata load", d_rdata, t.rdata);
                    lastD = t.rdata;
                end
            end
            check("stall_f", 32'(stall_f), 32'(i_req && !nIV));
            check("stall_m", 32'(stall_m), 32'(d_req && !nDV));
            pI   = i_req;
            pD   = d_req;
            pAck = m_ack;
            pIV  = nIV;
            pDV  = nDV;
        end
    end

    task automatic waitValid(bit isData);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(isData ? d_valid : i_valid) && cnt < 200);
        if (cnt >= 200) check(isData ? "d_valid timeout" : "i_valid timeout", 32'(1), 32'(0));
    endtask

    task automatic runFetch(int n);
        txn_t x;
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            x.addr  = 32'h1000 + ($urandom_range(0, 63) << 2);
            x.we    = 1'b0;
            x.wdata = '0;
            x.be    = '0;
            x.rdata = romWord(x.addr);
            iQ.push_back(x);
            i_addr = x.addr;
            i_req  = 1'b1;
            waitValid(1'b0);
            @(posedge clk);
            #1;
            i_req  = 1'b0;
            i_addr = $urandom;
        end
    endtask

    task automatic runData(int n);
        txn_t        x;
        logic [31:0] old;
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            x.addr  = 32'h20000 + ($urandom_range(0, 7) << 2);
            x.we    = ($urandom_range(0, 2) == 0);
            x.wdata = $urandom;
            x.be    = 4'($urandom_range(0, 15));
            old     = refMem.exists(x.addr) ? refMem[x.addr] : 32'h0;
            x.rdata = old;
            if (x.we) refMem[x.addr] = merge(old, x.wdata, x.be);
            dQ.push_back(x);
            d_addr  = x.addr;
            d_we    = x.we;
            d_wdata = x.wdata;
            d_be    = x.be;
            d_req   = 1'b1;
            waitValid(1'b1);
            @(posedge clk);
            #1;
            d_req   = 1'b0;
            d_we    = 1'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = 4'($urandom);
        end
    endtask

    task automatic checkResetOutputs();
        check("rst m_req", 32'(m_req), 32'(0));
        check("rst m_we", 32'(m_we), 32'(0));
        check("rst m_addr", m_addr, 32'(0));
        check("rst m_wdata", m_wdata, 32'(0));
        check("rst m_be", 32'(m_be), 32'(0));
        check("rst i_rdata", i_rdata, 32'(0));
        check("rst d_rdata", d_rdata, 32'(0));
        check("rst valids", 32'({i_valid, d_valid}), 32'(0));
        check("rst stall_f", 32'(stall_f), 32'(i_req));
        check("rst stall_m", 32'(stall_m), 32'(d_req));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_be    = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_req   = 1'($urandom);
            i_addr  = $urandom;
            d_req   = 1'($urandom);
            d_we    = 1'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = 4'($urandom);
            #1;
            checkResetOutputs();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle m_req", 32'(m_req), 32'(0));
        end

        @(posedge clk);
        #1;
        busy   = 1'b0;
        port   = 1'b0;
        streak = 0;
        pI     = 1'b0;
        pD     = 1'b0;
        pAck   = 1'b0;
        pIV    = 1'b0;
        pDV    = 1'b0;
        lastD  = '0;
        respOn = 1'b1;
        monOn  = 1'b1;
        fork
            runFetch(60);
            runData(60);
        join
        @(negedge clk);
        monOn  = 1'b0;
        respOn = 1'b0;
        check("i queue drained", 32'(iQ.size()), 32'(0));
        check("d queue drained", 32'(dQ.size()), 32'(0));

        // reset while a load is being served, then a stray late ack
        @(posedge clk);
        #1;
        d_we   = 1'b0;
        d_addr = 32'h20040;
        d_req  = 1'b1;
        repeat (2) @(negedge clk);
        check("midop m_req up", 32'(m_req), 32'(1));
        rst = 1'b0;
        #1;
        check("midop async m_req drop", 32'(m_req), 32'(0));
        d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        lateAck = 1'b1;
        @(negedge clk);
        lateAck = 1'b0;
        repeat (4) begin
            check("late ack d_valid", 32'(d_valid), 32'(0));
            check("late ack m_req", 32'(m_req), 32'(0));
            check("late ack i_valid", 32'(i_valid), 32'(0));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, variable-latency memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the RISC-V pipeline. Latches a granted request and holds it on the memory side until the memory acknowledges. Returns read data to the granted port and drives the per-stage stall lines into the hazard logic. Data requests have priority, and a starvation guard guarantees fetch progress.

Parameters:
AW, 32, address width
DW, 32, data width (DW/8 byte enables)
STARVE_LIMIT, 4, max consecutive data grants issued while i_req is pending; must be ≥1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_req  in  1  fetch request, held until i_valid
i_addr  in  AW  fetch address
i_rdata  out  DW  fetched word, registered
i_valid  out  1  one-cycle pulse when fetch completes
d_req  in  1  data request, held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_be  in  DW/8  store byte enables
d_rdata  out  DW  load data, registered
d_valid  out  1  one-cycle pulse when data access completes
stall_f  out  1  combinational: i_req & ~i_valid
stall_m  out  1  combinational: d_req & ~d_valid
m_req  out  1  memory request, registered
m_we  out  1  memory write enable, registered
m_addr  out  AW  memory address, registered
m_wdata  out  DW  memory write data, registered
m_be  out  DW/8  memory byte enables, registered
m_rdata  in  DW  memory read data, valid with m_ack
m_ack  in  1  memory completion, one cycle; only meaningful while m_req=1

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset (rst=0, async) forces:
  - state IDLE; starve_cnt 0;
  - m_req, m_we, m_addr, m_wdata, m_be = 0;
  - i_rdata, d_rdata = 0; i_valid, d_valid = 0.
- IDLE arbitration is evaluated each cycle on the effective requests ei = i_req & ~i_valid and ed = d_req & ~d_valid. A completing requester is not re-granted in its valid cycle.
  - ed & (~ei | starve_cnt < STARVE_LIMIT) → SERVE_D. Latch d_addr, d_we, d_wdata, d_be into m_*. m_req=1 next cycle.
  - else if ei → SERVE_I. Latch i_addr into m_addr; m_we=0, m_be=0, m_wdata=0; m_req=1 next cycle.
  - else remain IDLE.
- starve_cnt (saturating, 0..STARVE_LIMIT) updates at grant time:
  - data grant with ei=1: increment;
  - data grant with ei=0: clear;
  - instruction grant: clear.
- SERVE_x: m_* held stable and requester inputs ignored until a rising edge with m_ack=1. On that edge:
  - m_req←0; state←IDLE;
  - x_valid←1 for exactly one cycle;
  - on a load or fetch, x_rdata←m_rdata;
  - on a store, d_rdata is unchanged and d_valid still pulses.
- Latency: request sampled at edge 0, m_req high in cycle 1. If m_ack arrives in cycle 1, x_valid is high in cycle 2. Minimum request-to-valid is 2 cycles; each extra memory wait cycle adds 1.
- Back-to-back: the cycle in which x_valid is high is an IDLE cycle and may grant the other port. The next request from the same port is granted one cycle later.
- m_ack while m_req=0 is ignored and has no effect.
- i_rdata and d_rdata hold their last value until overwritten.
- stall_f and stall_m are purely combinational and drop in the valid cycle.
- Reset mid-transaction: m_req drops immediately and asynchronously. A late m_ack after reset release is ignored, and no valid pulse is generated.

Test Plan:
1. Reset: rst=0 with random inputs → all outputs 0, stall_f=i_req. Release, idle 5 cycles → m_req stays 0.
2. Single fetch: i_req=1, i_addr=0x100; memory acks 3 cycles after m_req with m_rdata=0x00500093 → m_addr=0x100, m_we=0. i_valid pulses exactly once 4 cycles after m_req rises; i_rdata=0x00500093; stall_f high until that cycle.
3. Contention: i_req (0x100) and d_req load (0x2000) raised together, ack latency 1 → m_addr sequence 0x2000 then 0x100. d_valid precedes i_valid; no duplicate grant of 0x2000.
4. Starvation: d_req held continuously (distinct addresses) with i_req held, STARVE_LIMIT=4 → grants D,D,D,D,I,D…; starve_cnt returns to 0 after the I grant.
5. Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0011, prior d_rdata=0x12345678 → m_we=1, m_be=0011, m_wdata=0xDEADBEEF. d_valid pulses; d_rdata stays 0x12345678.
6. Reset mid-op: assert rst during SERVE_D with m_req=1 → m_req=0 asynchronously. Release rst, then pulse m_ack → no d_valid, state IDLE.
